div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 171 +++++++++++++++++
 tb/tb_div_iter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative 32-bit radix-2 restoring divider (signed / unsigned)
//
// Purpose:
//   Accepts one pair of operands, runs exactly 32 restoring steps (one per
//   cycle), then presents a sign-corrected quotient and remainder until the
//   consumer takes it. Latency from the accepting edge to the first out_valid
//   cycle is fixed at 32 edges, regardless of operand values.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid & ready are both 1 and
//   div_flush is 0. valid never depends on ready. The producer holds its data
//   stable while valid=1 and ready=0. div_flush cancels everything in flight
//   and overrides both handshakes. reset overrides div_flush.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset
//   div_flush  in   1   pipeline flush, cancels any in-flight divide
//   in_valid   in   1   operands valid
//   in_ready   out  1   block can accept operands (IDLE only)
//   div_signed in   1   1 = signed divide, 0 = unsigned divide
//   div_src1   in   32  dividend
//   div_src2   in   32  divisor
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   quotient   out  32  quotient result
//   remainder  out  32  remainder result
// -----------------------------------------------------------------------------
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        div_signed,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] prem_q, prem_d;   // partial remainder
  logic [31:0] dvd_q, dvd_d;     // dividend magnitude, shifts out MSB-first; quotient bits shift in
  logic [31:0] dvs_q, dvs_d;     // divisor magnitude
  logic [31:0] src1_q, src1_d;   // raw dividend, returned as remainder on divide-by-zero
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;

  // Operand magnitudes at the acceptance edge. 32'h8000_0000 maps to itself,
  // which is the correct unsigned magnitude 2^31.
  logic [31:0] src1_mag, src2_mag;
  assign src1_mag = (div_signed && div_src1[31]) ? (~div_src1 + 32'd1) : div_src1;
  assign src2_mag = (div_signed && div_src2[31]) ? (~div_src2 + 32'd1) : div_src2;

  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted value fits in 33 bits and bit 32 of the difference is a
  // reliable "went negative" flag.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] prem_nx;
  logic [31:0] dvd_nx;
  assign shifted = {prem_q, dvd_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign q_bit   = ~diff[32];
  assign prem_nx = q_bit ? diff[31:0] : shifted[31:0];
  assign dvd_nx  = {dvd_q[30:0], q_bit};

  // Sign correction of the final step's results. The 8000_0000 / -1 case
  // needs no special handling: magnitude 2^31 with equal signs stays 8000_0000.
  logic [31:0] q_fin, r_fin;
  assign q_fin = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~dvd_nx + 32'd1) : dvd_nx);
  assign r_fin = dz_q ? src1_q        : (r_neg_q ? (~prem_nx + 32'd1) : prem_nx);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    src1_d  = src1_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    if (div_flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_d   = src1_mag;
            dvs_d   = src2_mag;
            src1_d  = div_src1;
            q_neg_d = div_signed & (div_src1[31] ^ div_src2[31]);
            r_neg_d = div_signed & div_src1[31];
            dz_d    = (div_src2 == 32'd0);
            prem_d  = 32'd0;
            cnt_d   = 5'd0;
            state_d = CALC;
          end
        end
        CALC: begin
          prem_d = prem_nx;
          dvd_d  = dvd_nx;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            quo_d   = q_fin;
            rem_d   = r_fin;
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      prem_q  <= 32'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      src1_q  <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      src1_q  <= src1_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE) & ~div_flush;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter -- self-checking bench for div_iter
//
// All tasks start and end one time unit after a rising edge; inputs are driven
// and outputs sampled there. Expected results come from an arithmetic model of
// signed/unsigned division with the divide-by-zero and overflow rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_iter;

  logic        clk;
  logic        reset;
  logic        div_flush;
  logic        in_valid;
  logic        in_ready;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;

  div_iter dut (
    .clk        (clk),
    .reset      (reset),
    .div_flush  (div_flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] q,
                                output logic [31:0] r);
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one edge (assumes in_ready=1), then scrambles them.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    in_valid   = 1'b1;
    div_src1   = a;
    div_src2   = b;
    div_signed = s;
    step();
    in_valid   = 1'b0;
    div_src1   = $urandom;
    div_src2   = $urandom;
    div_signed = 1'($urandom_range(0, 1));
  endtask

  // Counts edges until out_valid is seen (lat = edges since acceptance).
  task automatic wait_valid(output int lat, output bit timed_out);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    timed_out = !out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset     = 1'b1;
    div_flush = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    div_signed = 1'b0;
    div_src1  = 32'd0;
    div_src2  = 32'd0;
    step();
    step();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
  endtask

  task automatic test_directed();
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic        vs [10];
    logic [31:0] eq, er;
    int lat;
    bit to;
    va = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678,
           32'h1234_5678, 32'd0, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF};
    vb = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0,
           32'd0, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'd1};
    vs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      model(va[i], vb[i], vs[i], eq, er);
      start_op(va[i], vb[i], vs[i]);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_busy in_ready got=%b exp=0", i, in_ready); end
      wait_valid(lat, to);
      checks++; if (to || lat != 32) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=32", i, lat); end
      checks++; if (quotient !== eq) begin errors++; $display("FAIL dir%0d_quotient got=%h exp=%h", i, quotient, eq); end
      checks++; if (remainder !== er) begin errors++; $display("FAIL dir%0d_remainder got=%h exp=%h", i, remainder, er); end
      step();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_idle in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er;
    logic s;
    int lat;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er);
      start_op(a, b, s);
      wait_valid(lat, to);
      checks++; if (to || lat != 32) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=32", i, lat); end
      checks++; if (quotient !== eq || remainder !== er) begin
        errors++;
        $display("FAIL rnd%0d_result a=%h b=%h s=%b got q=%h r=%h exp q=%h r=%h", i, a, b, s, quotient, remainder, eq, er);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eq, er;
    int lat;
    bit to;
    out_ready = 1'b1;
    // Operands presented while DONE must not be taken until IDLE.
    start_op(32'd1000, 32'd3, 1'b0);
    wait_valid(lat, to);
    in_valid = 1'b1; div_src1 = 32'd50; div_src2 = 32'd6; div_signed = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    model(32'd50, 32'd6, 1'b0, eq, er);
    start_op(32'd50, 32'd6, 1'b0);
    wait_valid(lat, to);
    checks++; if (to || lat != 32) begin errors++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
    checks++; if (quotient !== eq || remainder !== er) begin errors++; $display("FAIL b2b_result got q=%h r=%h exp q=%h r=%h", quotient, remainder, eq, er); end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] eq, er;
    int lat;
    bit to;
    out_ready = 1'b0;
    model(32'hFFFF_FF00, 32'd7, 1'b1, eq, er);
    start_op(32'hFFFF_FF00, 32'd7, 1'b1);
    wait_valid(lat, to);
    checks++; if (to || lat != 32) begin errors++; $display("FAIL bp_latency got=%0d exp=32", lat); end
    for (int c = 2; c <= 6; c++) begin
      step();
      checks++; if (out_valid !== 1'b1 || quotient !== eq || remainder !== er) begin
        errors++;
        $display("FAIL bp_hold cycle %0d out_valid=%b q=%h r=%h exp 1 q=%h r=%h", c, out_valid, quotient, remainder, eq, er);
      end
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    int lat;
    bit to;
    bit seen;
    out_ready = 1'b1;
    // Flush in CALC cycle 10.
    start_op(32'd12345, 32'd11, 1'b0);
    for (int c = 0; c < 10; c++) step();
    div_flush = 1'b1;
    in_valid  = 1'b1;  // flush must win over acceptance
    step();
    div_flush = 1'b0;
    in_valid  = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_calc_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin step(); if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_calc_no_result out_valid seen=1 exp 0"); end
    start_op(32'd9, 32'd3, 1'b0);
    wait_valid(lat, to);
    checks++; if (to || quotient !== 32'd3 || remainder !== 32'd0) begin errors++; $display("FAIL flush_calc_next got q=%h r=%h exp q=3 r=0", quotient, remainder); end
    step();

    // Flush in the first DONE cycle with out_ready=1.
    start_op(32'd777, 32'd5, 1'b0);
    for (int c = 0; c < 31; c++) step();
    @(posedge clk);
    div_flush = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_mask out_valid=%b exp 0", out_valid); end
    step();
    div_flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_idle in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin step(); if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_done_no_result out_valid seen=1 exp 0"); end
    start_op(32'd9, 32'd3, 1'b0);
    wait_valid(lat, to);
    checks++; if (to || lat != 32 || quotient !== 32'd3 || remainder !== 32'd0) begin errors++; $display("FAIL flush_done_next lat=%0d q=%h r=%h exp 32 q=3 r=0", lat, quotient, remainder); end
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b1;
    start_op(32'd4000, 32'd9, 1'b1);
    for (int c = 0; c < 20; c++) step();
    reset     = 1'b1;
    div_flush = 1'b1;  // reset must win over flush
    step();
    reset     = 1'b0;
    div_flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin errors++; $display("FAIL rst_mid_data q=%h r=%h exp 0/0", quotient, remainder); end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin step(); if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_no_result out_valid seen=1 exp 0"); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
